// File: rtl/float2int_serial.sv
// Serial float-to-integer decoder: expands a packed {exponent, mantissa} code into
// an unsigned integer by shifting the restored significand one bit per cycle.
module float2int_serial #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    parameter int OUT_W = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W-1:0] in_float,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_int,
    output logic                   busy
);

    // The largest code must fit without truncation.
    generate
        if (OUT_W < MAN_W + (1 << EXP_W) - 1) begin : g_width_check
            $error("float2int_serial: OUT_W too small for EXP_W/MAN_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;

    logic [EXP_W-1:0]   in_exp;
    logic [MAN_W-1:0]   in_man;

    assign in_exp = in_float[MAN_W +: EXP_W];
    assign in_man = in_float[MAN_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subnormal codes (e==0) carry no hidden one and need no shift.
                    if (in_exp == '0) begin
                        acc_d   = OUT_W'(in_man);
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        acc_d   = OUT_W'({1'b1, in_man});
                        cnt_d   = in_exp - EXP_W'(1);
                        state_d = (in_exp == EXP_W'(1)) ? DONE : SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_q << 1;
                cnt_d = cnt_q - EXP_W'(1);
                if (cnt_q == EXP_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_int   = acc_q;

endmodule
